uart_tx_feeder: RTL and testbench

- Byte buffer and issue controller between the UART receiver output (DV pulse plus byte) and the UART transmitter input (DV pulse plus byte, with Active and Done status).
- Absorbs receive bursts into a FIFO and launches one transmit at a time, only when the transmitter is idle.
- Turns the direct rx-to-tx echo path into a buffered path that does not lose bytes while the transmitter is busy, up to DEPTH bytes.

---
 rtl/uart_tx_feeder_if.sv | 45 ++++
 rtl/uart_tx_feeder.sv | 117 +++++++++++
 tb/tb_uart_tx_feeder.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_feeder_if.sv
// Byte feed from the UART receiver, launch/status toward the transmitter,
// and FIFO status. The slave side is the feeder; master is its environment.
interface uart_tx_feeder_if #(
   parameter int ADDR_W = 4
);
   logic            i_Rx_DV;
   logic [7:0]      i_Rx_Byte;
   logic            i_Tx_Active;
   logic            i_Tx_Done;
   logic            i_Clear_Ovf;
   logic            o_Tx_DV;
   logic [7:0]      o_Tx_Byte;
   logic [ADDR_W:0] o_Count;
   logic            o_Empty;
   logic            o_Full;
   logic            o_Overflow;

   modport slave (
      input  i_Rx_DV,
      input  i_Rx_Byte,
      input  i_Tx_Active,
      input  i_Tx_Done,
      input  i_Clear_Ovf,
      output o_Tx_DV,
      output o_Tx_Byte,
      output o_Count,
      output o_Empty,
      output o_Full,
      output o_Overflow
   );

   modport master (
      output i_Rx_DV,
      output i_Rx_Byte,
      output i_Tx_Active,
      output i_Tx_Done,
      output i_Clear_Ovf,
      input  o_Tx_DV,
      input  o_Tx_Byte,
      input  o_Count,
      input  o_Empty,
      input  o_Full,
      input  o_Overflow
   );
endinterface

// File: rtl/uart_tx_feeder.sv
// Buffers received UART bytes and issues them to the transmitter one at a
// time, launching only while the transmitter is idle.
module uart_tx_feeder #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic            i_Clock,
   input  logic            i_Rst_L,
   uart_tx_feeder_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT_DONE,
      GAP
   } state_t;

   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              ovf_q, ovf_d;
   logic [7:0]        tx_byte_q, tx_byte_d;
   logic [7:0]        mem_q [DEPTH];
   logic [7:0]        mem_d [DEPTH];

   logic full;
   logic pop;
   logic push;
   logic drop;

   // A pop frees a slot in the same edge, so a full FIFO still accepts.
   always_comb begin
      full = (count_q == FULL_CNT);
      pop  = (state_q == IDLE) && (count_q != '0) && !bus.i_Tx_Active;
      push = bus.i_Rx_DV && (!full || pop);
      drop = bus.i_Rx_DV && full && !pop;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (pop) state_d = LAUNCH;
         LAUNCH:    state_d = WAIT_DONE;
         WAIT_DONE: if (bus.i_Tx_Done) state_d = GAP;
         GAP:       state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      tx_byte_d = tx_byte_q;
      ovf_d     = ovf_q;
      mem_d     = mem_q;

      if (push) begin
         mem_d[wr_ptr_q] = bus.i_Rx_Byte;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end

      // Read uses the old array, so push+pop on one slot stays ordered.
      if (pop) begin
         tx_byte_d = mem_q[rd_ptr_q];
         rd_ptr_d  = rd_ptr_q + PTR_ONE;
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      if (drop) begin
         ovf_d = 1'b1;
      end else if (bus.i_Clear_Ovf) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (!i_Rst_L) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         tx_byte_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         tx_byte_q <= tx_byte_d;
      end
   end

   always_ff @(posedge i_Clock) begin
      mem_q <= mem_d;
   end

   assign bus.o_Tx_DV    = (state_q == LAUNCH);
   assign bus.o_Tx_Byte  = tx_byte_q;
   assign bus.o_Count    = count_q;
   assign bus.o_Empty    = (count_q == '0);
   assign bus.o_Full     = (count_q == FULL_CNT);
   assign bus.o_Overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder with a simple uart_tx model
// (Active while sending, Done pulse 20 cycles after each launch).
module tb_uart_tx_feeder;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   typedef logic [ADDR_W:0] cnt_t;

   logic clk = 1'b0;
   logic rst_l;
   logic force_busy;
   logic model_active;
   logic tx_done;
   bit   model_en;
   bit   chk_gap;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int dv_seen     = 0;
   int last_dv_cyc = -1;
   int done_cyc    = -1;

   logic [7:0] sb [$];

   uart_tx_feeder_if #(.ADDR_W(ADDR_W)) bus ();

   uart_tx_feeder #(
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
   ) dut (
      .i_Clock(clk),
      .i_Rst_L(rst_l),
      .bus    (bus)
   );

   assign bus.i_Tx_Active = force_busy | model_active;
   assign bus.i_Tx_Done   = tx_done;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin : monitor
      logic [7:0] exp_b;
      forever begin
         @(negedge clk);
         if (bus.o_Tx_DV === 1'b1) begin
            dv_seen++;
            vectors++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL tx_unexpected: got %02h, nothing expected",
                        bus.o_Tx_Byte);
            end else begin
               exp_b = sb.pop_front();
               if (bus.o_Tx_Byte !== exp_b) begin
                  miscompares++;
                  $display("FAIL tx_byte: got %02h, expected %02h",
                           bus.o_Tx_Byte, exp_b);
               end
            end
            if (chk_gap && done_cyc > last_dv_cyc) begin
               vectors++;
               if (cyc - done_cyc != 3) begin
                  miscompares++;
                  $display("FAIL done_to_dv: got %0d cycles, expected 3",
                           cyc - done_cyc);
               end
            end
            last_dv_cyc = cyc;
         end
      end
   end

   initial begin : tx_model
      model_active = 1'b0;
      tx_done      = 1'b0;
      forever begin
         @(negedge clk);
         if (model_en && bus.o_Tx_DV === 1'b1) begin
            model_active = 1'b1;
            repeat (20) @(negedge clk);
            model_active = 1'b0;
            tx_done      = 1'b1;
            done_cyc     = cyc;
            @(negedge clk);
            tx_done      = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic push_byte(input logic [7:0] b, input bit accept);
      bus.i_Rx_DV   = 1'b1;
      bus.i_Rx_Byte = b;
      if (accept) sb.push_back(b);
      @(negedge clk);
      bus.i_Rx_DV = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((sb.size() != 0 || model_active || tx_done || !bus.o_Empty)
             && n < budget) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (n >= budget) begin
         miscompares++;
         $display("FAIL drain: %0d bytes pending after %0d cycles, expected 0",
                  sb.size(), budget);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_l           = 1'b0;
      bus.i_Rx_DV     = 1'b1;
      bus.i_Rx_Byte   = 8'hFF;
      bus.i_Clear_Ovf = 1'b0;
      repeat (2) @(negedge clk);
      bus.i_Rx_DV = 1'b0;
      rst_l       = 1'b1;
      vectors += 6;
      if (bus.o_Count !== cnt_t'(0)) begin
         miscompares++;
         $display("FAIL rst_count: got %0d, expected 0", bus.o_Count);
      end
      if (bus.o_Empty !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_empty: got %b, expected 1", bus.o_Empty);
      end
      if (bus.o_Full !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_full: got %b, expected 0", bus.o_Full);
      end
      if (bus.o_Overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_ovf: got %b, expected 0", bus.o_Overflow);
      end
      if (bus.o_Tx_DV !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_dv: got %b, expected 0", bus.o_Tx_DV);
      end
      if (bus.o_Tx_Byte !== 8'h00) begin
         miscompares++;
         $display("FAIL rst_byte: got %02h, expected 00", bus.o_Tx_Byte);
      end
   endtask

   task automatic test_single();
      int c0;
      int d0;
      model_en   = 1'b1;
      force_busy = 1'b0;
      c0 = cyc;
      d0 = dv_seen;
      push_byte(8'hA5, 1'b1);
      vectors += 3;
      if (bus.o_Count !== cnt_t'(1)) begin
         miscompares++;
         $display("FAIL single_count1: got %0d, expected 1", bus.o_Count);
      end
      @(negedge clk);
      if (bus.o_Tx_DV !== 1'b1) begin
         miscompares++;
         $display("FAIL single_dv: got %b, expected 1", bus.o_Tx_DV);
      end
      if (bus.o_Count !== cnt_t'(0)) begin
         miscompares++;
         $display("FAIL single_count0: got %0d, expected 0", bus.o_Count);
      end
      wait_drain(200);
      vectors += 2;
      if (dv_seen - d0 != 1) begin
         miscompares++;
         $display("FAIL single_pulses: got %0d, expected 1", dv_seen - d0);
      end
      if (last_dv_cyc - c0 != 2) begin
         miscompares++;
         $display("FAIL single_latency: got %0d, expected 2", last_dv_cyc - c0);
      end
   endtask

   task automatic test_burst();
      int d0;
      int t;
      d0 = dv_seen;
      force_busy = 1'b1;
      @(negedge clk);
      for (int i = 1; i <= 5; i++) push_byte(8'(i), 1'b1);
      @(negedge clk);
      vectors += 2;
      if (bus.o_Count !== cnt_t'(5)) begin
         miscompares++;
         $display("FAIL burst_count: got %0d, expected 5", bus.o_Count);
      end
      if (dv_seen != d0) begin
         miscompares++;
         $display("FAIL burst_no_dv: got %0d pulses, expected 0", dv_seen - d0);
      end
      force_busy = 1'b0;
      t = 0;
      while (dv_seen == d0 && t < 10) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      chk_gap = 1'b1;
      wait_drain(400);
      chk_gap = 1'b0;
      vectors++;
      if (dv_seen - d0 != 5) begin
         miscompares++;
         $display("FAIL burst_pulses: got %0d, expected 5", dv_seen - d0);
      end
   endtask

   task automatic test_overflow();
      int d0;
      d0 = dv_seen;
      force_busy = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) begin
         push_byte(8'(8'h40 + i), i < DEPTH);
         if (i == DEPTH - 1) begin
            vectors += 2;
            if (bus.o_Full !== 1'b1) begin
               miscompares++;
               $display("FAIL ovf_full: got %b, expected 1", bus.o_Full);
            end
            if (bus.o_Overflow !== 1'b0) begin
               miscompares++;
               $display("FAIL ovf_early: got %b, expected 0", bus.o_Overflow);
            end
         end
      end
      vectors += 2;
      if (bus.o_Overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_set: got %b, expected 1", bus.o_Overflow);
      end
      if (bus.o_Count !== cnt_t'(DEPTH)) begin
         miscompares++;
         $display("FAIL ovf_count: got %0d, expected %0d", bus.o_Count, DEPTH);
      end
      bus.i_Clear_Ovf = 1'b1;
      push_byte(8'hEE, 1'b0);
      bus.i_Clear_Ovf = 1'b0;
      vectors++;
      if (bus.o_Overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_set_wins: got %b, expected 1", bus.o_Overflow);
      end
      bus.i_Clear_Ovf = 1'b1;
      @(negedge clk);
      bus.i_Clear_Ovf = 1'b0;
      vectors++;
      if (bus.o_Overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL ovf_clear: got %b, expected 0", bus.o_Overflow);
      end
      force_busy = 1'b0;
      wait_drain(1000);
      vectors++;
      if (dv_seen - d0 != DEPTH) begin
         miscompares++;
         $display("FAIL ovf_pulses: got %0d, expected %0d", dv_seen - d0, DEPTH);
      end
   endtask

   task automatic test_full_push_pop();
      int d0;
      d0 = dv_seen;
      force_busy = 1'b1;
      for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h90 + i), 1'b1);
      vectors++;
      if (bus.o_Full !== 1'b1) begin
         miscompares++;
         $display("FAIL pp_full: got %b, expected 1", bus.o_Full);
      end
      force_busy = 1'b0;
      push_byte(8'h7E, 1'b1);
      vectors += 2;
      if (bus.o_Overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL pp_ovf: got %b, expected 0", bus.o_Overflow);
      end
      if (bus.o_Count !== cnt_t'(DEPTH)) begin
         miscompares++;
         $display("FAIL pp_count: got %0d, expected %0d", bus.o_Count, DEPTH);
      end
      wait_drain(1000);
      vectors++;
      if (dv_seen - d0 != DEPTH + 1) begin
         miscompares++;
         $display("FAIL pp_pulses: got %0d, expected %0d",
                  dv_seen - d0, DEPTH + 1);
      end
   endtask

   task automatic test_wrap();
      int d0;
      int n;
      int t;
      int stalls;
      d0 = dv_seen;
      n  = 3 * DEPTH;
      stalls = 0;
      for (int i = 0; i < 8; i++) push_byte(8'(i), 1'b1);
      for (int i = 8; i < n; i++) begin
         t = 0;
         while (bus.o_Count >= cnt_t'(8) && t < 200) begin
            @(negedge clk);
            t++;
         end
         if (t >= 200) stalls++;
         push_byte(8'(i), 1'b1);
      end
      wait_drain(2000);
      vectors += 3;
      if (stalls != 0) begin
         miscompares++;
         $display("FAIL wrap_stall: got %0d stalls, expected 0", stalls);
      end
      if (bus.o_Overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL wrap_ovf: got %b, expected 0", bus.o_Overflow);
      end
      if (dv_seen - d0 != n) begin
         miscompares++;
         $display("FAIL wrap_pulses: got %0d, expected %0d", dv_seen - d0, n);
      end
   endtask

   task automatic test_reset_mid();
      int d0;
      int t;
      model_en   = 1'b0;
      force_busy = 1'b0;
      d0 = dv_seen;
      for (int i = 0; i < 5; i++) push_byte(8'(8'hC0 + i), 1'b1);
      force_busy = 1'b1;
      vectors += 2;
      if (bus.o_Count !== cnt_t'(4)) begin
         miscompares++;
         $display("FAIL mid_count4: got %0d, expected 4", bus.o_Count);
      end
      if (dv_seen - d0 != 1) begin
         miscompares++;
         $display("FAIL mid_launch: got %0d, expected 1", dv_seen - d0);
      end
      rst_l = 1'b0;
      @(negedge clk);
      rst_l = 1'b1;
      sb.delete();
      vectors += 5;
      if (bus.o_Count !== cnt_t'(0)) begin
         miscompares++;
         $display("FAIL mid_count0: got %0d, expected 0", bus.o_Count);
      end
      if (bus.o_Empty !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_empty: got %b, expected 1", bus.o_Empty);
      end
      if (bus.o_Tx_DV !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_dv: got %b, expected 0", bus.o_Tx_DV);
      end
      if (bus.o_Overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_ovf: got %b, expected 0", bus.o_Overflow);
      end
      if (bus.o_Tx_Byte !== 8'h00) begin
         miscompares++;
         $display("FAIL mid_byte: got %02h, expected 00", bus.o_Tx_Byte);
      end
      push_byte(8'hD7, 1'b1);
      repeat (10) @(negedge clk);
      vectors += 2;
      if (dv_seen - d0 != 1) begin
         miscompares++;
         $display("FAIL mid_hold: got %0d, expected 1", dv_seen - d0);
      end
      if (bus.o_Count !== cnt_t'(1)) begin
         miscompares++;
         $display("FAIL mid_queued: got %0d, expected 1", bus.o_Count);
      end
      force_busy = 1'b0;
      t = 0;
      while (dv_seen - d0 != 2 && t < 5) begin
         @(negedge clk);
         t++;
      end
      vectors += 2;
      if (dv_seen - d0 != 2) begin
         miscompares++;
         $display("FAIL mid_relaunch: got %0d, expected 2", dv_seen - d0);
      end
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL mid_sb: got %0d pending, expected 0", sb.size());
      end
   endtask

   initial begin
      rst_l           = 1'b0;
      force_busy      = 1'b0;
      model_en        = 1'b0;
      chk_gap         = 1'b0;
      bus.i_Rx_DV     = 1'b0;
      bus.i_Rx_Byte   = 8'h00;
      bus.i_Clear_Ovf = 1'b0;
      @(negedge clk);
      test_reset();
      test_single();
      test_burst();
      test_overflow();
      test_full_push_pop();
      test_wrap();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
